atm_controller: RTL
===================

// Module: atm_controller
// PURPOSE
//  ATM transaction controller; the responder to the card/keypad/amount stimulus interface.
//  Detects a card, collects a 4-digit PIN over a digit strobe and checks it against a stored PIN.
//  Then executes one deposit or withdrawal against an internal balance and reports the result as pulse/level flags.
//  After MAX_INTENTOS wrong PINs it locks until reset.
// PARAMETERS
//  PIN          16'h4756  correct PIN, 4 BCD nibbles, first digit in [15:12]
//  BALANCE_INIT 64'd0     balance loaded at reset
//  MAX_INTENTOS 3         wrong-PIN entries that cause lock (>=2)
//  TIMEOUT_CYC  1000      inactivity limit in clk cycles (used only with ATM_TIMEOUT_EN)
// PORTS
//  clk                  in   1   system clock, rising edge
//  rst                  in   1   asynchronous reset, active-low
//  tarjeta_recibida     in   1   card inserted (level)
//  digito               in   4   keypad digit, valid at digito_stb rise
//  digito_stb           in   1   digit strobe
//  tipo_trans           in   1   0=deposit, 1=withdrawal; sampled at monto_stb rise
//  monto                in   32  transaction amount; sampled at monto_stb rise
//  monto_stb            in   1   amount strobe
//  balance              out  64  current balance
//  balance_actualizado  out  1   1-cycle pulse: balance committed
//  entregar_dinero      out  1   1-cycle pulse: dispense cash (withdrawal OK)
//  pin_incorrecto       out  1   1-cycle pulse per wrong 4-digit entry
//  advertencia          out  1   level: MAX_INTENTOS-1 wrong entries reached
//  bloqueo              out  1   level: locked
//  fondos_insuficientes out  1   1-cycle pulse: withdrawal rejected
// BEHAVIOUR
//  - Single clock, asynchronous active-low reset. Reset: state=ESPERANDO_TARJETA, balance=BALANCE_INIT, counters 0, all flags 0.
//  - Strobes are edge-detected: event = stb & ~stb_q. A strobe held N cycles counts once.
//  - ESPERANDO_TARJETA: tarjeta_recibida=1 -> VERIFICAR_PIN. Clear digit count and shift register.
//  - VERIFICAR_PIN: each digito_stb event shifts digito in and increments cnt (0..3).
//    On the 4th event compare with PIN next cycle:
//    match -> ESPERANDO_MONTO, intentos=0, advertencia=0;
//    mismatch -> pin_incorrecto pulse, intentos+1, cnt=0, stay in VERIFICAR_PIN.
//    advertencia=1 when intentos==MAX_INTENTOS-1.
//    When intentos==MAX_INTENTOS -> BLOQUEO.
//  - ESPERANDO_MONTO: monto_stb event latches monto/tipo_trans -> DEPOSITO or RETIRO.
//  - DEPOSITO: balance += monto (zero-extended, saturate at 2^64-1); balance_actualizado pulse; -> ESPERANDO_TARJETA.
//  - RETIRO, monto<=balance: balance -= monto; balance_actualizado and entregar_dinero pulse together; -> ESPERANDO_TARJETA.
//    monto==0 is a valid withdrawal.
//  - RETIRO, monto>balance: fondos_insuficientes pulse, balance unchanged; -> ESPERANDO_TARJETA.
//  - Latency: result pulses go high exactly 2 cycles after the cycle the monto_stb event is seen. pin_incorrecto goes high 2 cycles after the 4th digit event.
//  - BLOQUEO: bloqueo=1 and advertencia=0. All inputs ignored. Exit only via rst.
//  - intentos and advertencia clear on entry to ESPERANDO_TARJETA.
//  - Ignored inputs:
//    tarjeta_recibida outside ESPERANDO_TARJETA;
//    monto_stb in VERIFICAR_PIN;
//    digito_stb outside VERIFICAR_PIN;
//    simultaneous digit+amount events act on the digit only.
//  - Reset mid-transaction aborts it: balance returns to BALANCE_INIT and no flag pulses.
// CONFIGURATION
//  ATM_TIMEOUT_EN defined:
//    Idle counter runs in VERIFICAR_PIN/ESPERANDO_MONTO and resets on any strobe event.
//    At TIMEOUT_CYC -> ESPERANDO_TARJETA, digits discarded, balance untouched, no flag.
//  ATM_TIMEOUT_EN undefined: no counter; the block waits indefinitely.
// TESTING
//  T1 PIN 4,7,5,6; deposit monto=10000 from 0 -> balance=10000, balance_actualizado 1 cycle, no other flag.
//  T2 PIN 4,7,5,7 then 4,7,5,6; withdraw 10000 from balance 10000 -> one pin_incorrecto; entregar_dinero+balance_actualizado; balance=0.
//  T3 Correct PIN; withdraw 10000 from balance 0 -> fondos_insuficientes 1 cycle; balance=0; back to idle.
//  T4 Three wrong PINs -> three pin_incorrecto pulses; advertencia after 2nd; bloqueo=1 after 3rd; later card and strobes ignored; rst low -> bloqueo=0.
//  T5 digito_stb held 3 cycles per digit; rst pulled low mid-PIN -> each digit counted once; after reset flags=0, state idle.
//  T6 (ATM_TIMEOUT_EN, TIMEOUT_CYC=20) card inserted, 2 digits, 20 idle cycles -> idle; next card with full correct PIN works normally.

Source files
------------

// File: rtl/atm_controller.sv
// ATM transaction controller: card detect, 4-digit PIN check with lockout, one deposit/withdrawal per card.
// Optional inactivity timeout enabled by defining ATM_TIMEOUT_EN.
module atm_controller #(
   parameter logic [15:0] PIN          = 16'h4756,
   parameter logic [63:0] BALANCE_INIT = 64'd0,
   parameter int          MAX_INTENTOS = 3,
   parameter int          TIMEOUT_CYC  = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tarjeta_recibida,
   input  logic [3:0]  digito,
   input  logic        digito_stb,
   input  logic        tipo_trans,
   input  logic [31:0] monto,
   input  logic        monto_stb,
   output logic [63:0] balance,
   output logic        balance_actualizado,
   output logic        entregar_dinero,
   output logic        pin_incorrecto,
   output logic        advertencia,
   output logic        bloqueo,
   output logic        fondos_insuficientes
);

   localparam int IW = $clog2(MAX_INTENTOS + 1);
   localparam logic [IW-1:0] MAX_I  = IW'(MAX_INTENTOS);
   localparam logic [IW-1:0] WARN_I = IW'(MAX_INTENTOS - 1);

   typedef enum logic [2:0] {
      ESPERANDO_TARJETA,
      VERIFICAR_PIN,
      ESPERANDO_MONTO,
      DEPOSITO,
      RETIRO,
      BLOQUEO
   } state_t;

   state_t        state;
   logic          dig_q;
   logic          mon_q;
   logic [15:0]   shift_reg;
   logic [1:0]    cnt;
   logic          comparar;
   logic [IW-1:0] intentos;
   logic [IW-1:0] intentos_inc;
   logic [31:0]   monto_q;
   logic          tipo_q;
   logic          dig_ev;
   logic          mon_ev;
   logic [64:0]   suma;
   logic          cabe;
   logic          timeout_hit;

   assign dig_ev       = digito_stb & ~dig_q;
   assign mon_ev       = monto_stb & ~mon_q;
   assign intentos_inc = intentos + IW'(1);
   assign suma         = {1'b0, balance} + {33'd0, monto_q};
   assign cabe         = ({32'd0, monto_q} <= balance);

`ifdef ATM_TIMEOUT_EN
   localparam logic [31:0] TO_LIM = 32'(TIMEOUT_CYC - 1);
   logic [31:0] idle_cnt;

   // Inactivity counter: restarts on every strobe event and outside the waiting states.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idle_cnt <= 32'd0;
      end else if ((state == VERIFICAR_PIN || state == ESPERANDO_MONTO) && !dig_ev && !mon_ev) begin
         idle_cnt <= idle_cnt + 32'd1;
      end else begin
         idle_cnt <= 32'd0;
      end
   end

   assign timeout_hit = (state == VERIFICAR_PIN || state == ESPERANDO_MONTO) &&
                        !dig_ev && !mon_ev && !comparar && (idle_cnt == TO_LIM);
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state                <= ESPERANDO_TARJETA;
         dig_q                <= 1'b0;
         mon_q                <= 1'b0;
         shift_reg            <= 16'd0;
         cnt                  <= 2'd0;
         comparar             <= 1'b0;
         intentos             <= '0;
         monto_q              <= 32'd0;
         tipo_q               <= 1'b0;
         balance              <= BALANCE_INIT;
         balance_actualizado  <= 1'b0;
         entregar_dinero      <= 1'b0;
         pin_incorrecto       <= 1'b0;
         advertencia          <= 1'b0;
         bloqueo              <= 1'b0;
         fondos_insuficientes <= 1'b0;
      end else begin
         dig_q                <= digito_stb;
         mon_q                <= monto_stb;
         balance_actualizado  <= 1'b0;
         entregar_dinero      <= 1'b0;
         pin_incorrecto       <= 1'b0;
         fondos_insuficientes <= 1'b0;
         if (timeout_hit) begin
            state       <= ESPERANDO_TARJETA;
            cnt         <= 2'd0;
            shift_reg   <= 16'd0;
            intentos    <= '0;
            advertencia <= 1'b0;
         end else begin
            case (state)
               ESPERANDO_TARJETA: begin
                  cnt         <= 2'd0;
                  shift_reg   <= 16'd0;
                  comparar    <= 1'b0;
                  intentos    <= '0;
                  advertencia <= 1'b0;
                  if (tarjeta_recibida) state <= VERIFICAR_PIN;
               end
               // The fourth digit arms a compare that runs on the following cycle.
               VERIFICAR_PIN: begin
                  if (comparar) begin
                     comparar <= 1'b0;
                     if (shift_reg == PIN) begin
                        state       <= ESPERANDO_MONTO;
                        intentos    <= '0;
                        advertencia <= 1'b0;
                     end else begin
                        pin_incorrecto <= 1'b1;
                        intentos       <= intentos_inc;
                        cnt            <= 2'd0;
                        if (intentos_inc == MAX_I) begin
                           state       <= BLOQUEO;
                           bloqueo     <= 1'b1;
                           advertencia <= 1'b0;
                        end else if (intentos_inc == WARN_I) begin
                           advertencia <= 1'b1;
                        end
                     end
                  end else if (dig_ev) begin
                     shift_reg <= {shift_reg[11:0], digito};
                     cnt       <= cnt + 2'd1;
                     if (cnt == 2'd3) comparar <= 1'b1;
                  end
               end
               ESPERANDO_MONTO: begin
                  if (mon_ev && !dig_ev) begin
                     monto_q <= monto;
                     tipo_q  <= tipo_trans;
                     state   <= tipo_trans ? RETIRO : DEPOSITO;
                  end
               end
               DEPOSITO: begin
                  balance             <= suma[64] ? {64{1'b1}} : suma[63:0];
                  balance_actualizado <= 1'b1;
                  state               <= ESPERANDO_TARJETA;
               end
               RETIRO: begin
                  if (cabe) begin
                     balance             <= balance - {32'd0, monto_q};
                     balance_actualizado <= 1'b1;
                     entregar_dinero     <= 1'b1;
                  end else begin
                     fondos_insuficientes <= 1'b1;
                  end
                  state <= ESPERANDO_TARJETA;
               end
               BLOQUEO: begin
                  bloqueo     <= 1'b1;
                  advertencia <= 1'b0;
               end
               default: state <= ESPERANDO_TARJETA;
            endcase
         end
      end
   end

endmodule
